// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences a run of NUM_FRAMES frame requests to the feeder,
// tracks each frame's byte stream and side-info completion, and flags faults
// (timeout, bad header, missing side info) through a sticky error bit.
module frame_scheduler #(
    parameter int unsigned NUM_FRAMES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  start_frame,
    input  logic        stop,
    input  logic        downstream_ready,
    input  logic        byte_valid,
    input  logic        valid_header,
    input  logic [10:0] frame_size,
    input  logic        side_info_done,
    output logic        frame_num_ov,
    output logic [6:0]  frame_num_od,
    output logic        busy,
    output logic        frame_done,
    output logic        error,
    output logic [15:0] frames_done_count
);

    localparam int unsigned FW = 7;
    localparam int unsigned SW = 11;
    localparam int unsigned CW = 16;
    localparam int unsigned RW = 8;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HDR_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HDR,
        STREAM,
        WAIT_READY
    } state_t;

    state_t          state;
    logic [FW-1:0]   cur_frame;
    logic [RW-1:0]   run_left;
    logic [SW-1:0]   remaining;
    logic [TW-1:0]   timer;
    logic            si_seen;

    logic            timer_expired;
    logic            si_now;
    logic [CW-1:0]   count_next;

    // Idle-cycle budget is used up on this cycle if no qualifying event arrives
    assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));
    // Side info counts if seen earlier or arriving together with this byte
    assign si_now        = si_seen | side_info_done;
    // Completed-frame counter saturates rather than wrapping
    assign count_next    = (frames_done_count == {CW{1'b1}}) ? frames_done_count
                                                             : frames_done_count + CW'(1);

    // Run sequencer: state, counters and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cur_frame         <= '0;
            run_left          <= '0;
            remaining         <= '0;
            timer             <= '0;
            si_seen           <= 1'b0;
            frame_num_ov      <= 1'b0;
            frame_num_od      <= '0;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
            error             <= 1'b0;
            frames_done_count <= '0;
        end else begin
            frame_num_ov <= 1'b0;
            frame_done   <= 1'b0;
            if (state != IDLE && stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            cur_frame         <= start_frame;
                            run_left          <= RW'(NUM_FRAMES);
                            error             <= 1'b0;
                            frames_done_count <= '0;
                            busy              <= 1'b1;
                            frame_num_ov      <= 1'b1;
                            frame_num_od      <= start_frame;
                            state             <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        timer <= '0;
                        state <= WAIT_HDR;
                    end
                    WAIT_HDR: begin
                        if (valid_header) begin
                            timer <= '0;
                            if (frame_size > SW'(HDR_BYTES)) begin
                                remaining <= frame_size - SW'(HDR_BYTES);
                                si_seen   <= 1'b0;
                                state     <= STREAM;
                            end else begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else if (timer_expired) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    STREAM: begin
                        if (byte_valid) begin
                            timer <= '0;
                            if (remaining == SW'(1)) begin
                                remaining <= '0;
                                si_seen   <= 1'b0;
                                if (si_now) begin
                                    frame_done        <= 1'b1;
                                    frames_done_count <= count_next;
                                    run_left          <= run_left - RW'(1);
                                    state             <= WAIT_READY;
                                end else begin
                                    error <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end else begin
                                remaining <= remaining - SW'(1);
                                si_seen   <= si_now;
                            end
                        end else begin
                            si_seen <= si_now;
                            if (timer_expired) begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                timer <= timer + TW'(1);
                            end
                        end
                    end
                    WAIT_READY: begin
                        if (run_left == '0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (downstream_ready) begin
                            cur_frame    <= cur_frame + FW'(1);
                            frame_num_ov <= 1'b1;
                            frame_num_od <= cur_frame + FW'(1);
                            state        <= ISSUE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed stimulus with a transaction-level expectation
// model (busy/error/count/frame_done levels plus a queue of expected requests).
module tb_frame_scheduler;

    localparam int unsigned NUM = 2;
    localparam int unsigned TMO = 4096;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  start_frame;
    logic        stop;
    logic        downstream_ready;
    logic        byte_valid;
    logic        valid_header;
    logic [10:0] frame_size;
    logic        side_info_done;
    logic        frame_num_ov;
    logic [6:0]  frame_num_od;
    logic        busy;
    logic        frame_done;
    logic        error;
    logic [15:0] frames_done_count;

    frame_scheduler #(
        .NUM_FRAMES    (NUM),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .start_frame      (start_frame),
        .stop             (stop),
        .downstream_ready (downstream_ready),
        .byte_valid       (byte_valid),
        .valid_header     (valid_header),
        .frame_size       (frame_size),
        .side_info_done   (side_info_done),
        .frame_num_ov     (frame_num_ov),
        .frame_num_od     (frame_num_od),
        .busy             (busy),
        .frame_done       (frame_done),
        .error            (error),
        .frames_done_count(frames_done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   nchecks = 0;
    int   nerr    = 0;

    // expectation model
    bit   chk_en = 1'b0;
    bit   m_busy = 1'b0;
    bit   m_error = 1'b0;
    bit   m_done = 1'b0;
    int   m_count = 0;
    int   m_cur = 0;
    int   m_left = 0;
    int   exp_q[$];
    bit   prev_ov = 1'b0;
    bit   prev_done = 1'b0;
    int   last_od = -1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("error", 32'(error), 32'(m_error));
            check("frames_done_count", 32'(frames_done_count), 32'(m_count));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("ov_back_to_back", 32'(frame_num_ov & prev_ov), 32'(0));
            check("done_back_to_back", 32'(frame_done & prev_done), 32'(0));
            if (frame_num_ov) begin
                if (exp_q.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL unexpected_request: got frame %0d expected none (t=%0t)",
                             frame_num_od, $time);
                end else begin
                    check("request_num", 32'(frame_num_od), 32'(exp_q.pop_front()));
                end
                last_od = int'(frame_num_od);
            end
            prev_ov   = frame_num_ov;
            prev_done = frame_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int sf);
        start       = 1'b1;
        start_frame = 7'(sf);
        exp_q.push_back(sf);
        tick();
        start   = 1'b0;
        m_busy  = 1'b1;
        m_error = 1'b0;
        m_count = 0;
        m_cur   = sf;
        m_left  = NUM;
    endtask

    // Wait (bounded) for a request pulse, then step past the request cycle
    task automatic wait_req(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 4) begin
            @(negedge clk);
            cycles++;
            if (frame_num_ov) seen = 1'b1;
        end
        nchecks++;
        if (!seen) begin
            nerr++;
            $display("FAIL request_wait: got no request expected one within 4 cycles (t=%0t)", $time);
        end
        tick();
    endtask

    // Header plus (size-4) bytes; si_at = byte index carrying side info (-1 none),
    // stop_at = byte index carrying stop (-1 none), gap = idle cycles between bytes
    task automatic send_frame(input int size, input int si_at, input int stop_at, input int gap);
        int n;
        bit ok;
        n  = size - 4;
        ok = (si_at >= 0) && (si_at < n);
        byte_valid = 1'b1;
        tick();
        byte_valid   = 1'b0;
        valid_header = 1'b1;
        frame_size   = 11'(size);
        tick();
        valid_header = 1'b0;
        for (int i = 0; i < n; i++) begin
            byte_valid     = 1'b1;
            side_info_done = (i == si_at);
            stop           = (i == stop_at);
            if (i == 1) begin
                start        = 1'b1;
                start_frame  = 7'd99;
                valid_header = 1'b1;
                frame_size   = 11'd9;
            end
            tick();
            byte_valid     = 1'b0;
            side_info_done = 1'b0;
            start          = 1'b0;
            valid_header   = 1'b0;
            if (i == stop_at) begin
                stop   = 1'b0;
                m_busy = 1'b0;
                return;
            end
            if (i == n - 1) begin
                if (ok) begin
                    m_done = 1'b1;
                    m_count++;
                    m_left--;
                    if (m_left > 0 && downstream_ready) begin
                        m_cur = (m_cur + 1) % 128;
                        exp_q.push_back(m_cur);
                    end
                    tick();
                    m_done = 1'b0;
                    if (m_left == 0) m_busy = 1'b0;
                end else begin
                    m_error = 1'b1;
                    m_busy  = 1'b0;
                end
            end else begin
                repeat (gap) tick();
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ov"},    32'(frame_num_ov), 32'(0));
        check({tag, "_od"},    32'(frame_num_od), 32'(0));
        check({tag, "_busy"},  32'(busy), 32'(0));
        check({tag, "_done"},  32'(frame_done), 32'(0));
        check({tag, "_error"}, 32'(error), 32'(0));
        check({tag, "_count"}, 32'(frames_done_count), 32'(0));
    endtask

    initial begin
        int c;
        rst              = 1'b0;
        start            = 1'b0;
        start_frame      = '0;
        stop             = 1'b0;
        downstream_ready = 1'b1;
        byte_valid       = 1'b0;
        valid_header     = 1'b0;
        frame_size       = '0;
        side_info_done   = 1'b0;

        // reset state, then quiet idle after release
        #12;
        check_all_zero("reset");
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (5) tick();

        // two-frame run from frame 5 with 417-byte frames
        do_start(5);
        wait_req(c);
        send_frame(417, 10, -1, 0);
        wait_req(c);
        send_frame(417, 412, -1, 1);
        tick();
        check("run_count", 32'(frames_done_count), 32'(2));
        check("run_busy", 32'(busy), 32'(0));
        check("run_error", 32'(error), 32'(0));
        check("run_last_req", 32'(last_od), 32'(6));

        // frame number wraps 127 -> 0; minimum legal frame_size 5
        do_start(127);
        wait_req(c);
        send_frame(5, 0, -1, 0);
        wait_req(c);
        check("wrap_req", 32'(last_od), 32'(0));
        send_frame(5, 0, -1, 0);
        tick();
        check("wrap_count", 32'(frames_done_count), 32'(2));

        // header timeout after TMO idle cycles
        do_start(10);
        wait_req(c);
        repeat (TMO - 1) tick();
        tick();
        m_error = 1'b1;
        m_busy  = 1'b0;
        tick();
        check("tmo_error", 32'(error), 32'(1));
        check("tmo_busy", 32'(busy), 32'(0));

        // stop in IDLE and start+stop together have no effect
        stop = 1'b1;
        tick();
        start = 1'b1;
        start_frame = 7'd33;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) tick();
        check("idle_stop_error", 32'(error), 32'(1));

        // new start clears error; stop while waiting for header
        do_start(30);
        check("restart_clears_error", 32'(error), 32'(0));
        wait_req(c);
        stop = 1'b1;
        tick();
        stop   = 1'b0;
        m_busy = 1'b0;
        tick();
        check("stop_hdr_busy", 32'(busy), 32'(0));

        // full frame without side info is a fault
        do_start(60);
        wait_req(c);
        send_frame(8, -1, -1, 0);
        tick();
        check("nosi_error", 32'(error), 32'(1));
        check("nosi_count", 32'(frames_done_count), 32'(0));

        // frame_size of 4 is a fault
        do_start(70);
        wait_req(c);
        valid_header = 1'b1;
        frame_size   = 11'd4;
        tick();
        valid_header = 1'b0;
        m_error = 1'b1;
        m_busy  = 1'b0;
        tick();
        check("short_hdr_error", 32'(error), 32'(1));

        // downstream back-pressure holds off the next request
        downstream_ready = 1'b0;
        do_start(20);
        wait_req(c);
        send_frame(6, 1, -1, 0);
        repeat (100) tick();
        downstream_ready = 1'b1;
        exp_q.push_back(21);
        m_cur = 21;
        wait_req(c);
        check("ready_latency_le2", 32'(c <= 2), 32'(1));
        check("ready_req", 32'(last_od), 32'(21));
        send_frame(6, 1, -1, 0);
        tick();
        check("ready_count", 32'(frames_done_count), 32'(2));

        // stop mid-stream
        do_start(40);
        wait_req(c);
        send_frame(20, 3, 5, 0);
        tick();
        check("stop_stream_busy", 32'(busy), 32'(0));
        check("stop_stream_error", 32'(error), 32'(0));

        // stop together with the final byte: no frame_done
        do_start(41);
        wait_req(c);
        send_frame(6, 0, 1, 0);
        tick();
        check("stop_final_count", 32'(frames_done_count), 32'(0));

        // asynchronous reset mid-run after one completed frame
        do_start(42);
        wait_req(c);
        send_frame(6, 0, -1, 0);
        wait_req(c);
        check("pre_rst_count", 32'(frames_done_count), 32'(1));
        valid_header = 1'b1;
        frame_size   = 11'd100;
        tick();
        valid_header = 1'b0;
        byte_valid   = 1'b1;
        repeat (3) tick();
        byte_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        m_busy  = 1'b0;
        m_error = 1'b0;
        m_count = 0;
        m_done  = 1'b0;
        check_all_zero("async_rst");
        #4 rst = 1'b1;
        repeat (6) tick();
        check("post_rst_busy", 32'(busy), 32'(0));
        check("req_queue_empty", 32'(exp_q.size()), 32'(0));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter NUM_FRAMES, default 8, meaning frames played per start command (1..128).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, meaning max idle clk cycles while waiting for header or byte.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 start  input  1  one-cycle pulse, begin run at start_frame.
REQ-006 start_frame  input  7  first frame number of run.
REQ-007 stop  input  1  one-cycle pulse, abort run.
REQ-008 downstream_ready  input  1  consumer can accept another frame.
REQ-009 byte_valid  input  1  feeder byte strobe (feeder axiov).
REQ-010 valid_header  input  1  header-finder pulse, header (4 bytes) consumed.
REQ-011 frame_size  input  11  frame length in bytes incl. header, valid with valid_header.
REQ-012 side_info_done  input  1  side-info parser output-valid pulse.
REQ-013 frame_num_ov  output  1  one-cycle request pulse to feeder.
REQ-014 frame_num_od  output  7  frame number, valid with frame_num_ov.
REQ-015 busy  output  1  high while a run is active.
REQ-016 frame_done  output  1  one-cycle pulse per completed frame.
REQ-017 error  output  1  sticky fault flag.
REQ-018 frames_done_count  output  16  completed frames since last accepted start, saturating at 0xFFFF.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT_HDR, STREAM, WAIT_READY.
REQ-020 IDLE: start accepted -> cur_frame=start_frame, run_left=NUM_FRAMES, error=0, count=0, go ISSUE; busy=1 from next cycle.
REQ-021 ISSUE: frame_num_ov=1 for exactly one cycle with frame_num_od=cur_frame; go WAIT_HDR; timer cleared.
REQ-022 WAIT_HDR: valid_header with frame_size>4 -> remaining=frame_size-4, si_seen=0, go STREAM; frame_size<=4 -> fault.
REQ-023 WAIT_HDR/STREAM: timer counts cycles without qualifying event (valid_header / byte_valid), cleared on each; timer reaching TIMEOUT_CYCLES -> fault.
REQ-024 STREAM: each byte_valid decrements remaining; side_info_done sets si_seen (same-cycle with final byte counts).
REQ-025 STREAM: byte_valid with remaining==1 -> if si_seen (or side_info_done same cycle) frame_done pulse next cycle, count+1, run_left-1, go WAIT_READY; else fault.
REQ-026 WAIT_READY: run_left==0 -> IDLE, busy=0; else downstream_ready=1 -> cur_frame+1 (mod 128, 127 wraps to 0), go ISSUE; else hold.
REQ-027 Fault: error=1, go IDLE, busy=0; error holds until next accepted start.
REQ-028 stop in any non-IDLE state -> IDLE next cycle, no frame_done, error unchanged; stop in IDLE no effect.
REQ-029 start while busy ignored; start and stop same cycle: stop wins, start ignored.
REQ-030 valid_header outside WAIT_HDR and byte_valid outside STREAM ignored.
REQ-031 frame_done, frame_num_ov SHALL be registered outputs, never high two consecutive cycles.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, frame_num_ov=0, frame_num_od=0, busy=0, frame_done=0, error=0, frames_done_count=0, timer/remaining/si_seen=0, mid-run included.
REQ-033 After rst returns to 1, block SHALL stay IDLE until a start pulse.

Verification
REQ-034 start, start_frame=5, NUM_FRAMES=2, frame_size=417, 413 bytes + side_info_done each, downstream_ready=1 -> frame_num_od 5 then 6, two frame_done, count=2, busy falls, error=0.
REQ-035 start_frame=127, NUM_FRAMES=2 -> second request frame_num_od=0.
REQ-036 No valid_header after request for 4096 cycles -> error=1, busy=0; next start clears error.
REQ-037 Full frame bytes without side_info_done -> error=1, no frame_done, count=0.
REQ-038 downstream_ready=0 after frame 1 for 100 cycles -> no frame_num_ov; raise -> request frame_num_od=start_frame+1 within 2 cycles.
REQ-039 stop mid-STREAM, then rst=0 mid-run on a second start -> both return IDLE, no frame_done, all outputs at reset values after rst.
